// File: rtl/md_unit.sv
// Multiply/divide unit with architectural HI/LO registers.
// Fixed-latency multiply and radix-2 restoring divide; results are written to HI/LO when done pulses.
module md_unit #(
  parameter int WIDTH    = 32,
  parameter int MULT_LAT = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] data_in1,
  input  logic [WIDTH-1:0] data_in2,
  input  logic             mthi,
  input  logic             mtlo,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             busy,
  output logic             done
);

  // state | meaning
  // IDLE  | waiting; accepts start or mthi/mtlo writes
  // MUL   | multiply in flight, counts down MULT_LAT cycles
  // DIV   | WIDTH restoring iterations, then one fix-up cycle

  localparam logic [3:0] ALU_MULT  = 4'h8;
  localparam logic [3:0] ALU_MULTU = 4'h9;
  localparam logic [3:0] ALU_DIV   = 4'hA;
  localparam logic [3:0] ALU_DIVU  = 4'hB;
  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV} state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             sgn_q, sgn_d;
  logic             negq_q, negq_d;
  logic             negr_q, negr_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] quo_q, quo_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;

  logic             is_mul, is_div, is_signed;
  logic [WIDTH-1:0] a_mag, b_mag;
  logic [WIDTH:0]   rem_shift, rem_sub;
  logic             rem_ge;
  logic [2*WIDTH-1:0] a_ext, b_ext, prod;
  logic [WIDTH-1:0] q_fix, r_fix;
  logic             done_c;

  always_comb begin
    is_mul    = (op == ALU_MULT) || (op == ALU_MULTU);
    is_div    = (op == ALU_DIV)  || (op == ALU_DIVU);
    is_signed = (op == ALU_MULT) || (op == ALU_DIV);
    a_mag     = (is_signed && data_in1[WIDTH-1]) ? -data_in1 : data_in1;
    b_mag     = (is_signed && data_in2[WIDTH-1]) ? -data_in2 : data_in2;

    // One restoring step: shift in the next dividend bit, subtract if it fits.
    rem_shift = {rem_q, quo_q[WIDTH-1]};
    rem_sub   = rem_shift - {1'b0, b_q};
    rem_ge    = (rem_shift >= {1'b0, b_q});

    // Sign-extending to 2*WIDTH makes the low 2*WIDTH product bits correct for signed operands.
    a_ext = {{WIDTH{sgn_q & a_q[WIDTH-1]}}, a_q};
    b_ext = {{WIDTH{sgn_q & b_q[WIDTH-1]}}, b_q};
    prod  = a_ext * b_ext;

    q_fix = negq_q ? -quo_q : quo_q;
    r_fix = negr_q ? -rem_q : rem_q;
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    sgn_d   = sgn_q;
    negq_d  = negq_q;
    negr_d  = negr_q;
    a_d     = a_q;
    b_d     = b_q;
    quo_d   = quo_q;
    rem_d   = rem_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    done_c  = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          if (is_mul) begin
            a_d     = data_in1;
            b_d     = data_in2;
            sgn_d   = is_signed;
            cnt_d   = CW'(MULT_LAT - 1);
            state_d = S_MUL;
          end else if (is_div) begin
            a_d     = data_in1;
            b_d     = b_mag;
            sgn_d   = is_signed;
            quo_d   = a_mag;
            rem_d   = '0;
            negq_d  = is_signed & (data_in1[WIDTH-1] ^ data_in2[WIDTH-1]);
            negr_d  = is_signed & data_in1[WIDTH-1];
            cnt_d   = CW'(WIDTH);
            state_d = S_DIV;
          end
        end else begin
          if (mthi) hi_d = data_in1;
          if (mtlo) lo_d = data_in1;
        end
      end
      S_MUL: begin
        if (cnt_q == '0) begin
          hi_d    = prod[2*WIDTH-1:WIDTH];
          lo_d    = prod[WIDTH-1:0];
          done_c  = 1'b1;
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      S_DIV: begin
        if (cnt_q != '0) begin
          rem_d = rem_ge ? rem_sub[WIDTH-1:0] : rem_shift[WIDTH-1:0];
          quo_d = {quo_q[WIDTH-2:0], rem_ge};
          cnt_d = cnt_q - CW'(1);
        end else begin
          // Fix-up cycle: apply signs, or substitute the divide-by-zero result.
          if (b_q == '0) begin
            lo_d = '1;
            hi_d = a_q;
          end else begin
            lo_d = q_fix;
            hi_d = r_fix;
          end
          done_c  = 1'b1;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      sgn_q   <= 1'b0;
      negq_q  <= 1'b0;
      negr_q  <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      quo_q   <= '0;
      rem_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sgn_q   <= sgn_d;
      negq_q  <= negq_d;
      negr_q  <= negr_d;
      a_q     <= a_d;
      b_q     <= b_d;
      quo_q   <= quo_d;
      rem_q   <= rem_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

  assign hi   = hi_q;
  assign lo   = lo_q;
  assign busy = (state_q != S_IDLE);
  assign done = done_c;

endmodule

// File: tb/tb_md_unit.sv
// Self-checking bench for md_unit: directed WIDTH=32 cases plus a WIDTH=16 randomized run
// against an arithmetic reference model.
module tb_md_unit;

  localparam logic [3:0] OP_MULT  = 4'h8;
  localparam logic [3:0] OP_MULTU = 4'h9;
  localparam logic [3:0] OP_DIV   = 4'hA;
  localparam logic [3:0] OP_DIVU  = 4'hB;
  localparam int LAT16 = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic [3:0]  op;
  logic [31:0] d1, d2;
  logic        st32, mh32, ml32, st16, mh16, ml16;
  logic [31:0] hi32, lo32;
  logic [15:0] hi16, lo16;
  logic        busy32, done32, busy16, done16;
  bit          cur16;

  logic [31:0] hi_s, lo_s;
  logic        busy_s, done_s;
  assign hi_s   = cur16 ? {16'h0, hi16} : hi32;
  assign lo_s   = cur16 ? {16'h0, lo16} : lo32;
  assign busy_s = cur16 ? busy16 : busy32;
  assign done_s = cur16 ? done16 : done32;

  int errors = 0;
  int checks = 0;

  md_unit #(.WIDTH(32), .MULT_LAT(4)) dut32 (
    .clk(clk), .rst_n(rst_n), .start(st32), .op(op),
    .data_in1(d1), .data_in2(d2), .mthi(mh32), .mtlo(ml32),
    .hi(hi32), .lo(lo32), .busy(busy32), .done(done32)
  );

  md_unit #(.WIDTH(16), .MULT_LAT(LAT16)) dut16 (
    .clk(clk), .rst_n(rst_n), .start(st16), .op(op),
    .data_in1(d1[15:0]), .data_in2(d2[15:0]), .mthi(mh16), .mtlo(ml16),
    .hi(hi16), .lo(lo16), .busy(busy16), .done(done16)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic drive(input bit s, input bit h, input bit l);
    if (cur16) begin st16 = s; mh16 = h; ml16 = l; end
    else       begin st32 = s; mh32 = h; ml32 = l; end
  endtask

  task automatic mt_write(input bit h, input bit l, input logic [31:0] v);
    @(negedge clk);
    d1 = v;
    drive(1'b0, h, l);
    @(negedge clk);
    drive(1'b0, 1'b0, 1'b0);
  endtask

  // Issues one operation and returns cycles from accept to done, plus HI/LO after the write.
  task automatic run_op(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b,
                        input bit mt_busy, input bit mt_with_start,
                        output int lat, output logic [31:0] h, output logic [31:0] l);
    logic [31:0] pre_h, pre_l;
    bit got_done;
    @(negedge clk);
    pre_h = hi_s;
    pre_l = lo_s;
    op = o; d1 = a; d2 = b;
    drive(1'b1, mt_with_start, 1'b0);
    lat = 0;
    got_done = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      lat++;
      if (lat == 1) begin
        drive(1'b0, 1'b0, 1'b0);
        chk("busy_after_accept", busy_s, 1);
      end
      if (lat == 2 && mt_busy) begin
        d1 = 32'h1234;
        drive(1'b0, 1'b1, 1'b1);
      end
      if (lat == 3 && mt_busy) drive(1'b0, 1'b0, 1'b0);
      if (done_s) begin
        got_done = 1'b1;
        break;
      end
    end
    drive(1'b0, 1'b0, 1'b0);
    if (!got_done) chk("done_timeout", 0, 1);
    chk("hi_hold_busy", hi_s, pre_h);
    chk("lo_hold_busy", lo_s, pre_l);
    @(posedge clk);
    #1;
    h = hi_s;
    l = lo_s;
    chk("busy_after_done", busy_s, 0);
  endtask

  function automatic void ref16(input logic [3:0] o, input logic [15:0] a, input logic [15:0] b,
                                output logic [15:0] h, output logic [15:0] l);
    int sa, sb, ua, ub, q, r;
    longint p;
    sa = int'($signed(a));
    sb = int'($signed(b));
    ua = int'(a);
    ub = int'(b);
    h = '0; l = '0;
    case (o)
      OP_MULT:  begin p = longint'(sa) * longint'(sb); h = p[31:16]; l = p[15:0]; end
      OP_MULTU: begin p = longint'(ua) * longint'(ub); h = p[31:16]; l = p[15:0]; end
      OP_DIV: begin
        if (b == 16'h0)                           begin l = 16'hFFFF; h = a; end
        else if (a == 16'h8000 && b == 16'hFFFF)  begin l = 16'h8000; h = 16'h0; end
        else begin q = sa / sb; r = sa % sb; l = q[15:0]; h = r[15:0]; end
      end
      OP_DIVU: begin
        if (b == 16'h0) begin l = 16'hFFFF; h = a; end
        else begin q = ua / ub; r = ua % ub; l = q[15:0]; h = r[15:0]; end
      end
      default: ;
    endcase
  endfunction

  function automatic logic [15:0] pick16();
    logic [15:0] v;
    v = 16'($urandom);
    case ($urandom_range(0, 7))
      0: v = 16'h0000;
      1: v = 16'h8000;
      2: v = 16'hFFFF;
      3: v = 16'h0001;
      4: v = 16'h7FFF;
      default: ;
    endcase
    return v;
  endfunction

  initial begin
    #5ms;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "simulation time limit");
  end

  initial begin
    int lat;
    logic [31:0] h, l;
    logic [15:0] eh, el, m_hi, m_lo, a16, b16;
    logic [3:0] ops [4];
    bit seen_done;

    ops = '{OP_MULT, OP_MULTU, OP_DIV, OP_DIVU};
    cur16 = 1'b0;
    rst_n = 1'b0;
    op = '0; d1 = '0; d2 = '0;
    st32 = 0; mh32 = 0; ml32 = 0; st16 = 0; mh16 = 0; ml16 = 0;
    #23;
    chk("rst_hi", hi32, 0);
    chk("rst_lo", lo32, 0);
    chk("rst_busy", busy32, 0);
    chk("rst_done", done32, 0);
    @(negedge clk);
    rst_n = 1'b1;

    run_op(OP_MULT, 32'hFFFFFFFE, 32'h3, 0, 0, lat, h, l);
    chk("mult_lat", lat, 4);
    chk("mult_hi", h, 32'hFFFFFFFF);
    chk("mult_lo", l, 32'hFFFFFFFA);

    run_op(OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 0, 0, lat, h, l);
    chk("multu_hi", h, 32'hFFFFFFFE);
    chk("multu_lo", l, 32'h00000001);

    run_op(OP_DIV, 32'hFFFFFFF9, 32'h2, 0, 0, lat, h, l);
    chk("div_lat", lat, 33);
    chk("div_lo", l, 32'hFFFFFFFD);
    chk("div_hi", h, 32'hFFFFFFFF);

    run_op(OP_DIVU, 32'd100, 32'd0, 0, 0, lat, h, l);
    chk("divz_lat", lat, 33);
    chk("divz_lo", l, 32'hFFFFFFFF);
    chk("divz_hi", h, 32'd100);

    run_op(OP_DIV, 32'h80000000, 32'hFFFFFFFF, 0, 0, lat, h, l);
    chk("divmin_lo", l, 32'h80000000);
    chk("divmin_hi", h, 32'h0);

    run_op(OP_DIVU, 32'd50, 32'd7, 1, 0, lat, h, l);
    chk("mt_busy_hi", h, 32'd1);
    chk("mt_busy_lo", l, 32'd7);

    mt_write(1, 0, 32'h1234);
    chk("mthi_idle", hi32, 32'h1234);
    chk("mthi_lo_keep", lo32, 32'd7);
    mt_write(0, 1, 32'h5678);
    chk("mtlo_idle", lo32, 32'h5678);
    mt_write(1, 1, 32'hCAFE);
    chk("mtboth_hi", hi32, 32'hCAFE);
    chk("mtboth_lo", lo32, 32'hCAFE);

    // Invalid op with start: nothing changes and the unit stays idle.
    @(negedge clk);
    op = 4'h3; d1 = 32'h11; d2 = 32'h22; st32 = 1'b1;
    @(negedge clk);
    st32 = 1'b0;
    chk("badop_busy", busy32, 0);
    chk("badop_hi", hi32, 32'hCAFE);
    chk("badop_lo", lo32, 32'hCAFE);

    // start wins over a simultaneous mthi, whose write is dropped.
    run_op(OP_MULTU, 32'd2, 32'd3, 0, 1, lat, h, l);
    chk("startprio_hi", h, 32'h0);
    chk("startprio_lo", l, 32'd6);

    // Reset in the middle of a divide.
    mt_write(1, 1, 32'hA5A5A5A5);
    @(negedge clk);
    op = OP_DIV; d1 = 32'hFFFFFFF9; d2 = 32'h2; st32 = 1'b1;
    @(negedge clk);
    st32 = 1'b0;
    repeat (9) @(negedge clk);
    chk("pre_abort_busy", busy32, 1);
    rst_n = 1'b0;
    #1;
    chk("abort_hi", hi32, 0);
    chk("abort_lo", lo32, 0);
    chk("abort_busy", busy32, 0);
    chk("abort_done", done32, 0);
    @(negedge clk);
    rst_n = 1'b1;
    seen_done = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (done32 || busy32) seen_done = 1'b1;
    end
    chk("abort_no_done", seen_done, 0);
    chk("abort_hi_after", hi32, 0);

    // Randomized WIDTH=16 regression.
    cur16 = 1'b1;
    chk("rst16_hi", hi16, 0);
    chk("rst16_lo", lo16, 0);
    m_hi = '0;
    m_lo = '0;
    for (int n = 0; n < 150; n++) begin
      if ($urandom_range(0, 4) == 0) begin
        bit wh, wl;
        logic [15:0] v;
        v  = 16'($urandom);
        wh = 1'($urandom_range(0, 1));
        wl = wh ? 1'($urandom_range(0, 1)) : 1'b1;
        mt_write(wh, wl, {16'h0, v});
        if (wh) m_hi = v;
        if (wl) m_lo = v;
        chk("r_mt_hi", hi16, m_hi);
        chk("r_mt_lo", lo16, m_lo);
      end else begin
        logic [3:0] o;
        o   = ops[$urandom_range(0, 3)];
        a16 = pick16();
        b16 = pick16();
        run_op(o, {16'h0, a16}, {16'h0, b16}, 0, 0, lat, h, l);
        ref16(o, a16, b16, eh, el);
        chk("r_lat", lat, (o == OP_MULT || o == OP_MULTU) ? LAT16 : 17);
        chk("r_hi", h, {16'h0, eh});
        chk("r_lo", l, {16'h0, el});
        m_hi = eh;
        m_lo = el;
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/md_unit.md
MD_UNIT -- requirements
Module: md_unit

Interface
REQ-001 Parameter WIDTH, default 32, SHALL set operand, HI and LO width (legal: even values 8..64).
REQ-002 Parameter MULT_LAT, default 4, SHALL set the multiply latency in cycles from accepted start to done (legal 1..8).
REQ-003 clk  input  1  SHALL be the single clock; all state SHALL update on its rising edge.
REQ-004 rst_n  input  1  SHALL be an asynchronous, active-low reset.
REQ-005 start  input  1  SHALL request an operation; it is sampled only when busy=0.
REQ-006 op  input  4  SHALL select the operation, using the head.v ALUOp codes ALU_MULT, ALU_MULTU, ALU_DIV and ALU_DIVU; any other code with start is a no-op.
REQ-007 data_in1  input  WIDTH  SHALL carry the multiplicand or dividend, captured at accept.
REQ-008 data_in2  input  WIDTH  SHALL carry the multiplier or divisor, captured at accept.
REQ-009 mthi, mtlo  input  1 each  SHALL write data_in1 into HI or LO respectively when busy=0.
REQ-010 hi, lo  output  WIDTH each  SHALL carry the architectural HI/LO register contents.
REQ-011 busy  output  1  SHALL be high while an operation is in flight.
REQ-012 done  output  1  SHALL be a one-cycle pulse in the cycle HI/LO take the new result.

Function
REQ-013 The state machine SHALL have exactly three states: IDLE, MUL, DIV.
REQ-014 In IDLE, start=1 with a valid op SHALL capture the operands and op, go to MUL or DIV, and assert busy from the next cycle.
REQ-015 start with an invalid op SHALL leave the state, HI and LO unchanged.
REQ-016 MUL SHALL last MULT_LAT cycles, then write the 2*WIDTH-bit product (HI=upper, LO=lower), pulse done, and return to IDLE.
REQ-017 MULT SHALL treat operands as two's complement; MULTU SHALL treat them as unsigned.
REQ-018 DIV SHALL use a radix-2 restoring iteration on magnitudes, one quotient bit per cycle, for exactly WIDTH cycles, then one fix-up cycle (WIDTH+1 total), then write the result, pulse done, and return to IDLE.
REQ-019 Division results SHALL be LO=quotient and HI=remainder.
REQ-020 Signed quotients SHALL truncate toward zero; the signed remainder SHALL take the sign of the dividend.
REQ-021 Divide by zero SHALL give LO=all ones and HI=dividend, with the same latency as a normal divide.
REQ-022 Signed MIN / -1 SHALL give LO=MIN and HI=0.
REQ-023 While busy=1, hi and lo SHALL hold their pre-operation values; start, mthi and mtlo SHALL be ignored.
REQ-024 In IDLE, start SHALL have priority over mthi/mtlo; a simultaneous write SHALL be dropped.
REQ-025 In IDLE, mthi=mtlo=1 together SHALL write both HI and LO.
REQ-026 A start accepted in the same cycle that done is high SHALL NOT occur, since busy is still high in that cycle; the earliest next accept SHALL be the cycle after done.
REQ-027 A new operation's done SHALL NOT be asserted earlier than its stated latency, regardless of operand values.

Reset
REQ-028 rst_n=0 SHALL immediately force state=IDLE and hi=0, lo=0, busy=0, done=0, and clear all internal counters.
REQ-029 Reset asserted mid-operation SHALL abort the operation with no write to HI or LO.
REQ-030 After rst_n deasserts, the first accepted start SHALL be at the first rising edge with start=1.

Verification
REQ-031 WIDTH=32: MULT 0xFFFFFFFE x 0x00000003 -> done exactly 4 cycles after accept; HI=0xFFFFFFFF, LO=0xFFFFFFFA.
REQ-032 MULTU 0xFFFFFFFF x 0xFFFFFFFF -> HI=0xFFFFFFFE, LO=0x00000001.
REQ-033 DIV -7 / 2 -> done 33 cycles after accept; LO=0xFFFFFFFD, HI=0xFFFFFFFF.
REQ-034 DIVU 100 / 0 -> LO=0xFFFFFFFF, HI=100.
REQ-035 DIV 0x80000000 / 0xFFFFFFFF -> LO=0x80000000, HI=0.
REQ-036 mthi=1 with data_in1=0x1234 during busy -> HI unchanged.
REQ-037 Same write in IDLE -> HI=0x1234.
REQ-038 rst_n pulse at DIV cycle 10 -> HI=LO=0, busy=0 immediately, and no done pulse.
REQ-039 WIDTH=16 randomized regression against a signed/unsigned reference model: all four ops, including zero, MIN and -1 operands.
